// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable frame format, 3-sample majority vote per bit,
// parity/framing/overrun reporting behind a ready/clear handshake.
module uart_rx_os #(
  parameter int CLK_FRQ    = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 rx_clear,
  output logic                 rx_busy
);
  localparam int DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync_p0, sync_p1, s_rx, s_rx_d;
  logic [15:0]          div_cnt;
  logic [15:0]          tick_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 tick, last_tick, vote_tick, vote, exp_par, final_stop, complete;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign s_rx       = sync_p1;
  assign tick       = (state != S_IDLE) && (div_cnt == 16'(DIV - 1));
  assign last_tick  = tick && (tick_cnt == 16'(OVERSAMPLE - 1));
  assign vote_tick  = tick && (tick_cnt == 16'(MID + 1));
  assign vote       = maj3(samp[0], samp[1], s_rx);
  assign exp_par    = (^shreg) ^ (PARITY == 1);
  assign final_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign complete   = (state == S_STOP) && vote_tick && final_stop;

  // Stage p0/p1: two-flop synchroniser, preset to the idle line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      s_rx_d  <= 1'b1;
    end else begin
      sync_p0 <= rx_in;
      sync_p1 <= sync_p0;
      s_rx_d  <= sync_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      rx_busy       <= 1'b0;
      rx_data       <= '0;
      rx_data_ready <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= last_tick ? 16'd0 : tick_cnt + 16'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end

      if (tick && tick_cnt == 16'(MID - 1)) samp[0] <= s_rx;
      if (tick && tick_cnt == 16'(MID))     samp[1] <= s_rx;

      case (state)
        S_IDLE: begin
          perr    <= 1'b0;
          ferr    <= 1'b0;
          bit_cnt <= '0;
          if (s_rx_d && !s_rx) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (vote_tick && vote) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end else if (last_tick) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (vote_tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (last_tick) begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (vote_tick) perr <= (PARITY != 0) && (vote != exp_par);
          if (last_tick) state <= S_STOP;
        end
        S_STOP: begin
          if (vote_tick && !vote) ferr <= 1'b1;
          // The frame completes mid-stop-bit so a following start edge is never missed
          if (complete) begin
            state   <= vote ? S_IDLE : S_WAIT_HIGH;
            rx_busy <= !vote;
          end else if (last_tick) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (s_rx) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase

      if (complete) begin
        if (!rx_data_ready || rx_clear) begin
          rx_data       <= shreg;
          rx_parity_err <= perr;
          rx_frame_err  <= ferr | ~vote;
          rx_data_ready <= 1'b1;
          if (rx_clear) rx_overrun <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_clear) begin
        rx_data_ready <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_overrun    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: four frame formats (8N1, 7E1, 8N2, 9O2) at 32 clk/bit,
// directed scenarios followed by randomized frames against a frame-level model.
module tb_uart_rx_os;
  localparam int BIT_CLK = 32;
  localparam int M       = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       line  [4];
  logic       clear [4];
  logic       rdy   [4];
  logic       perr  [4];
  logic       ferr  [4];
  logic       ovr   [4];
  logic       busy  [4];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] d3;

  int cfg_db  [4] = '{8, 7, 8, 9};
  int cfg_par [4] = '{0, 2, 0, 1};
  int cfg_sb  [4] = '{1, 1, 2, 2};

  logic [8:0] m_data [4];
  logic       m_rdy  [4];
  logic       m_perr [4];
  logic       m_ferr [4];
  logic       m_ovr  [4];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FRQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx_in(line[0]), .rx_data(d0), .rx_data_ready(rdy[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_overrun(ovr[0]),
    .rx_clear(clear[0]), .rx_busy(busy[0]));
  uart_rx_os #(.CLK_FRQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
               .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx_in(line[1]), .rx_data(d1), .rx_data_ready(rdy[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_overrun(ovr[1]),
    .rx_clear(clear[1]), .rx_busy(busy[1]));
  uart_rx_os #(.CLK_FRQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx_in(line[2]), .rx_data(d2), .rx_data_ready(rdy[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_overrun(ovr[2]),
    .rx_clear(clear[2]), .rx_busy(busy[2]));
  uart_rx_os #(.CLK_FRQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
               .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .rx_in(line[3]), .rx_data(d3), .rx_data_ready(rdy[3]),
    .rx_parity_err(perr[3]), .rx_frame_err(ferr[3]), .rx_overrun(ovr[3]),
    .rx_clear(clear[3]), .rx_busy(busy[3]));

  function automatic logic [8:0] get_data(input int u);
    case (u)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      2:       return {1'b0, d2};
      default: return d3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial frame image, LSB first: start, data, optional parity, stop bits
  function automatic logic [15:0] build(input int u, input logic [8:0] d, input logic pbit,
                                        input logic [1:0] stops, output int nb);
    logic [15:0] b;
    int n;
    b = '1;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < cfg_db[u]; i++) begin b[n] = d[i]; n++; end
    if (cfg_par[u] != 0) begin b[n] = pbit; n++; end
    for (int i = 0; i < cfg_sb[u]; i++) begin b[n] = stops[i]; n++; end
    nb = n;
    return b;
  endfunction

  // Parity error when the count of ones (data plus parity bit) has the wrong oddness
  function automatic logic ref_perr(input int u, input logic [8:0] d, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (cfg_par[u] == 0) return 1'b0;
    if (cfg_par[u] == 2) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  task automatic send_frame(input int u, input logic [15:0] b, input int nb,
                            input int gl_at, input int gl_len, input int max_clk);
    int c;
    c = 0;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < BIT_CLK; k++) begin
        if (max_clk >= 0 && c >= max_clk) return;
        line[u] = b[i] ^ ((c >= gl_at) && (c < gl_at + gl_len));
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic m_reset_all();
    for (int u = 0; u < 4; u++) begin
      m_data[u] = '0; m_rdy[u] = 0; m_perr[u] = 0; m_ferr[u] = 0; m_ovr[u] = 0;
    end
  endtask

  task automatic m_complete(input int u, input logic [8:0] d, input logic pe,
                            input logic fe, input logic clr_same);
    if (!m_rdy[u] || clr_same) begin
      m_data[u] = d; m_perr[u] = pe; m_ferr[u] = fe; m_rdy[u] = 1'b1;
      if (clr_same) m_ovr[u] = 1'b0;
    end else begin
      m_ovr[u] = 1'b1;
    end
  endtask

  task automatic clr(input int u);
    clear[u] = 1'b1;
    @(negedge clk);
    clear[u] = 1'b0;
    m_rdy[u] = 0; m_perr[u] = 0; m_ferr[u] = 0; m_ovr[u] = 0;
  endtask

  task automatic check_unit(input int u, input string tag);
    chk($sformatf("%s u%0d data", tag, u), 32'(get_data(u)), 32'(m_data[u]));
    chk($sformatf("%s u%0d ready", tag, u), 32'(rdy[u]), 32'(m_rdy[u]));
    chk($sformatf("%s u%0d perr", tag, u), 32'(perr[u]), 32'(m_perr[u]));
    chk($sformatf("%s u%0d ferr", tag, u), 32'(ferr[u]), 32'(m_ferr[u]));
    chk($sformatf("%s u%0d overrun", tag, u), 32'(ovr[u]), 32'(m_ovr[u]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset_all();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b;
    int          nb;
    logic [8:0]  d;
    logic [8:0]  mask;
    logic        pbit;
    logic [1:0]  stops;
    logic        last_stop;
    int          gap;

    for (int u = 0; u < 4; u++) begin line[u] = 1'b1; clear[u] = 1'b0; end
    do_reset();

    // Reset state
    for (int u = 0; u < 4; u++) begin
      check_unit(u, "reset");
      chk($sformatf("reset u%0d busy", u), 32'(busy[u]), 32'd0);
    end

    // 8N1 0xA5; ready must rise right after the final stop vote tick (edge 5 + 32*9 + 2*(M+1))
    b = build(0, 9'h0A5, 1'b0, 2'b11, nb);
    fork
      send_frame(0, b, nb, -1, 0, -1);
      begin
        repeat (5 + BIT_CLK * 9 + 2 * (M + 1) - 1) @(posedge clk);
        #1 chk("latency ready low", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #1 chk("latency ready high", 32'(rdy[0]), 32'd1);
      end
    join
    m_complete(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    check_unit(0, "8N1 A5");
    chk("8N1 busy idle", 32'(busy[0]), 32'd0);
    clr(0);
    check_unit(0, "8N1 clear");
    chk("8N1 data holds", 32'(get_data(0)), 32'h0A5);

    // 7E1 0x41 with correct and then wrong parity bit
    b = build(1, 9'h041, 1'b0, 2'b11, nb);
    send_frame(1, b, nb, -1, 0, -1);
    m_complete(1, 9'h041, ref_perr(1, 9'h041, 1'b0), 1'b0, 1'b0);
    check_unit(1, "7E1 good");
    clr(1);
    b = build(1, 9'h041, 1'b1, 2'b11, nb);
    send_frame(1, b, nb, -1, 0, -1);
    m_complete(1, 9'h041, ref_perr(1, 9'h041, 1'b1), 1'b0, 1'b0);
    check_unit(1, "7E1 bad");
    chk("7E1 perr set", 32'(perr[1]), 32'd1);
    clr(1);

    // 8N2 with the second stop bit low
    b = build(2, 9'h0C3, 1'b0, 2'b01, nb);
    send_frame(2, b, nb, -1, 0, -1);
    line[2] = 1'b1;
    repeat (10) @(negedge clk);
    m_complete(2, 9'h0C3, 1'b0, 1'b1, 1'b0);
    check_unit(2, "8N2 stop2 low");
    clr(2);

    // Break: line low for 40 bit times gives one completion, then busy until the line rises
    b = build(2, 9'h000, 1'b0, 2'b00, nb);
    send_frame(2, b, nb, -1, 0, -1);
    repeat (40 * BIT_CLK - nb * BIT_CLK) @(negedge clk);
    m_complete(2, 9'h000, 1'b0, 1'b1, 1'b0);
    check_unit(2, "break");
    chk("break busy", 32'(busy[2]), 32'd1);
    line[2] = 1'b1;
    repeat (5) @(negedge clk);
    chk("break released busy", 32'(busy[2]), 32'd0);
    repeat (200) @(negedge clk);
    check_unit(2, "break after");
    clr(2);

    // False start: 10-clk low pulse on an idle line
    line[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("false start busy", 32'(busy[0]), 32'd1);
    repeat (4) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("false start idle", 32'(busy[0]), 32'd0);
    check_unit(0, "false start");

    // Glitch on the tick-M sample of data bit 3 (frame bit 4); sample edge 5+32*4+2*M sees line from two edges earlier
    b = build(0, 9'h000, 1'b0, 2'b11, nb);
    send_frame(0, b, nb, BIT_CLK * 4 + 2 * M + 2, 2, -1);
    m_complete(0, 9'h000, 1'b0, 1'b0, 1'b0);
    check_unit(0, "glitch");
    clr(0);

    // Back-to-back 0x11, 0x22, 0x33; clear coincides with the third completion
    fork
      for (int i = 1; i <= 3; i++) begin
        b = build(0, 9'(i * 9'h011), 1'b0, 2'b11, nb);
        send_frame(0, b, nb, -1, 0, -1);
      end
      begin
        repeat (400) @(posedge clk);
        #1 chk("b2b f1 data", 32'(get_data(0)), 32'h011);
        chk("b2b f1 overrun", 32'(ovr[0]), 32'd0);
        repeat (440) @(posedge clk);
        #1 chk("b2b f2 data", 32'(get_data(0)), 32'h011);
        chk("b2b f2 overrun", 32'(ovr[0]), 32'd1);
        chk("b2b f2 ready", 32'(rdy[0]), 32'd1);
        repeat (2 * 10 * BIT_CLK + 5 + BIT_CLK * 9 + 2 * (M + 1) - 1 - 840) @(posedge clk);
        @(negedge clk);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
      end
    join
    m_data[0] = 9'h011; m_rdy[0] = 1; m_ovr[0] = 1;
    m_complete(0, 9'h033, 1'b0, 1'b0, 1'b1);
    check_unit(0, "b2b f3");

    // Reset during data bit 4 aborts the frame; transmitter abandons it too
    b = build(0, 9'h05A, 1'b0, 2'b11, nb);
    send_frame(0, b, nb, -1, 0, BIT_CLK * 5 + 10);
    line[0] = 1'b1;
    do_reset();
    for (int u = 0; u < 4; u++) begin
      check_unit(u, "midreset");
      chk($sformatf("midreset u%0d busy", u), 32'(busy[u]), 32'd0);
    end
    repeat (400) @(negedge clk);
    check_unit(0, "midreset quiet");
    send_frame(0, b, nb, -1, 0, -1);
    m_complete(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    check_unit(0, "after reset 5A");

    // Randomized frames on every format, random clears and idle gaps
    do_reset();
    for (int u = 0; u < 4; u++) begin
      mask = 9'((1 << cfg_db[u]) - 1);
      for (int f = 0; f < 6; f++) begin
        d     = 9'($urandom) & mask;
        pbit  = 1'($urandom_range(0, 1));
        stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        last_stop = stops[cfg_sb[u] - 1];
        b = build(u, d, pbit, stops, nb);
        send_frame(u, b, nb, -1, 0, -1);
        line[u] = 1'b1;
        m_complete(u, d, ref_perr(u, d, pbit),
                   (stops[0] == 1'b0) || (cfg_sb[u] == 2 && stops[1] == 1'b0), 1'b0);
        check_unit(u, $sformatf("rand f%0d", f));
        if ($urandom_range(0, 1) == 1) clr(u);
        gap = $urandom_range(0, 20) + (last_stop ? 0 : 4);
        repeat (gap) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Next-generation UART receiver with a parametrised frame format: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Samples the line on an oversampled tick and majority-votes each bit, so glitches on the line do not corrupt data.
- Reports parity, framing and overrun errors alongside the received data.
- Drop-in replacement for the existing receiver behind the console/terminal bridge. Keeps the same rx_data_ready / rx_clear handshake.

Parameters:
- CLK_FRQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: serial baud rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- rx_in  in  1  serial input, asynchronous, idle high.
- rx_data  out  DATA_BITS  last accepted data word, LSB = first bit received.
- rx_data_ready  out  1  new word available.
- rx_parity_err  out  1  parity mismatch on the latched word.
- rx_frame_err  out  1  a stop bit was sampled low on the latched word.
- rx_overrun  out  1  a frame completed while rx_data_ready=1.
- rx_clear  in  1  one-cycle pulse; clears ready and all error flags.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - State = IDLE.
  - The input synchroniser is preset to 1.
  - Reset asserted mid-frame aborts the frame; nothing is latched.
- Input synchroniser: two flops. All logic below uses the synchronised value s_rx.
- Tick generator:
  - DIV = CLK_FRQ/(BAUD_RATE*OVERSAMPLE), integer division.
  - The counter is held at 0 in IDLE and produces a tick every DIV clocks otherwise.
  - tick_cnt counts 0..OVERSAMPLE-1 within each bit and restarts at each bit boundary.
- Bit sampling:
  - Three samples are taken at ticks M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit value is the majority of the three, decided on tick M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - A falling edge on s_rx (1→0) moves the block to START.
- START:
  - If the start majority is 1, treat it as a false start and return to IDLE. Nothing is latched.
  - Otherwise go to DATA at the bit boundary (tick OVERSAMPLE-1).
- DATA:
  - Shift in DATA_BITS bits, LSB first.
  - After the last bit, go to PARITY if PARITY≠0, else go to STOP.
- PARITY:
  - Expected parity bit = XOR of the data bits, inverted if odd.
  - perr = (sampled parity bit ≠ expected).
- STOP:
  - Sample STOP_BITS stop bits. ferr = 1 if any stop majority is 0.
  - On the vote tick of the final stop bit, the frame completes.
  - After completion, go to IDLE if the final stop bit is 1, else go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until s_rx = 1, then go to IDLE.
  - This prevents a break condition from retriggering the receiver.
- Completion cycle, when rx_data_ready=0 or rx_clear=1 in the same cycle:
  - rx_data <= word.
  - rx_parity_err <= perr.
  - rx_frame_err <= ferr.
  - rx_data_ready <= 1.
  - rx_overrun <= 0 if rx_clear=1, else holds.
- Completion cycle, when rx_data_ready=1 and rx_clear=0:
  - The word is discarded. rx_data and the error flags hold.
  - rx_overrun <= 1.
- rx_clear without completion in the same cycle:
  - rx_data_ready, both error flags and rx_overrun are cleared the next cycle.
  - rx_data holds.
- Latency: rx_data_ready rises exactly 1 clk after the final stop-bit vote tick.
- Back-to-back frames:
  - Because completion happens mid-stop-bit, the receiver is in IDLE before the next start edge.
  - Frames with zero idle gap must be received.
- Width rules:
  - Tick counter ≥ 16 bits.
  - The bit counter must hold 0..8.
  - perr is forced to 0 when PARITY=0.

Test Plan (CLK_FRQ=3_200_000, BAUD_RATE=100_000, OVERSAMPLE=16 → DIV=2, 32 clk/bit):
- 8N1, send 0xA5 → rx_data=0xA5, rx_data_ready=1, all error flags 0. rx_clear pulse → ready=0 next clk, rx_data still 0xA5.
- 7E1 (DATA_BITS=7, PARITY=2), send 0x41 with parity bit 0 → rx_parity_err=0. Send 0x41 with parity bit 1 → rx_data=0x41, rx_parity_err=1.
- 8N2, second stop bit driven low → rx_frame_err=1, rx_data holds the received byte. Hold line low for 40 bit times (break) → exactly one completion, rx_busy=1 in WAIT_HIGH until the line rises, then IDLE.
- Glitches:
  - 10-clk low pulse on an idle line → false start, returns to IDLE, rx_data_ready stays 0.
  - Single-tick inverted glitch at tick M inside data bit 3 of 0x00 → majority vote rejects it, rx_data=0x00.
- Send 0x11, 0x22, 0x33 back-to-back with no rx_clear → rx_data=0x11, rx_overrun=1 after the second frame. rx_clear in the same cycle as the third completion → rx_data=0x33, ready=1, rx_overrun=0.
- Assert reset at data bit 4 of a frame → all outputs 0. The following clean 0x5A frame is received correctly.
